// File: rtl/alu_accum_seq.sv
// rtl/alu_accum_seq.sv - sequential ALU/accumulator with shift-add multiply
module alu_accum_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             persist,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [2:0]       op_sel,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [1:0]       currState,
  output logic [1:0]       nextState
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_LOAD = 2'b01;
  localparam logic [1:0] S_BUSY = 2'b10;
  localparam logic [1:0] S_HOLD = 2'b11;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOT  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2:0]         op_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] prod_q, mcand_q, prod_step;
  logic [WIDTH-1:0]   out_q, out_hi_q;
  logic               carry_q, ovf_q, zero_q, done_q;

  logic [WIDTH-1:0]   res_d;
  logic               carry_d, ovf_d;
  logic [WIDTH:0]     sum_w, diff_w;

  // Next-state decode from the current state and live inputs; reset wins.
  always_comb begin
    state_d = state_q;
    if (reset) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (load) state_d = S_LOAD;
        S_LOAD: state_d = (op_q == OP_MUL) ? S_BUSY : S_HOLD;
        S_BUSY: if (cnt_q == CNT_W'(1)) state_d = S_HOLD;
        default: begin
          if (!persist)  state_d = S_IDLE;
          else if (load) state_d = S_LOAD;
        end
      endcase
    end
  end

  // Single-cycle ALU result and flags from the captured operands.
  always_comb begin
    sum_w   = {1'b0, a_q} + {1'b0, b_q};
    diff_w  = {1'b0, a_q} - {1'b0, b_q};
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_d   = sum_w[WIDTH-1:0];
        carry_d = sum_w[WIDTH];
        ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        res_d   = diff_w[WIDTH-1:0];
        carry_d = diff_w[WIDTH];
        ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND:  res_d = a_q & b_q;
      OP_OR:   res_d = a_q | b_q;
      OP_XOR:  res_d = a_q ^ b_q;
      OP_NOT:  res_d = ~a_q;
      OP_PASS: res_d = b_q;
      default: res_d = '0;
    endcase
  end

  // One shift-add step: add the shifted multiplicand when the multiplier LSB is set.
  always_comb begin
    prod_step = prod_q + (b_q[0] ? mcand_q : '0);
  end

  // State, operand capture, multiply iteration and result/flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      out_q    <= '0;
      out_hi_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == S_HOLD) && (state_q != S_HOLD);
      case (state_q)
        S_IDLE: begin
          if (load) begin
            a_q  <= num1;
            b_q  <= num2;
            op_q <= op_sel;
          end
        end
        S_LOAD: begin
          if (op_q == OP_MUL) begin
            prod_q  <= '0;
            mcand_q <= {{WIDTH{1'b0}}, a_q};
            cnt_q   <= CNT_W'(WIDTH);
          end else begin
            out_q    <= res_d;
            out_hi_q <= '0;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= (res_d == '0);
          end
        end
        S_BUSY: begin
          prod_q  <= prod_step;
          mcand_q <= mcand_q << 1;
          b_q     <= b_q >> 1;
          cnt_q   <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            out_q    <= prod_step[WIDTH-1:0];
            out_hi_q <= prod_step[2*WIDTH-1:WIDTH];
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= (prod_step == '0);
          end
        end
        default: begin
          // Chained load: the held result becomes operand A.
          if (persist && load) begin
            a_q  <= out_q;
            b_q  <= num2;
            op_q <= op_sel;
          end
        end
      endcase
    end
  end

  assign out       = out_q;
  assign out_hi    = out_hi_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign done      = done_q;
  assign busy      = (state_q == S_LOAD) || (state_q == S_BUSY);
  assign currState = state_q;
  assign nextState = state_d;

endmodule

// File: tb/tb_alu_accum_seq.sv
// tb/tb_alu_accum_seq.sv - randomized self-checking bench for alu_accum_seq
module tb_alu_accum_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, load, persist;
  logic [W-1:0] num1, num2;
  logic [2:0]   op_sel;
  logic [W-1:0] out, out_hi;
  logic         carry, ovf, zero, busy, done;
  logic [1:0]   currState, nextState;

  int checks = 0;
  int errors = 0;

  // reference model: phase name, operands and expected visible outputs
  int m_phase;  // 0 idle, 1 load, 2 busy, 3 hold
  int m_a, m_b, m_op, m_left;
  int m_out, m_hi, m_c, m_v, m_z, m_done;

  alu_accum_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .load(load), .persist(persist),
    .num1(num1), .num2(num2), .op_sel(op_sel),
    .out(out), .out_hi(out_hi), .carry(carry), .ovf(ovf), .zero(zero),
    .busy(busy), .done(done), .currState(currState), .nextState(nextState)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sgn(input int v);
    return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
  endfunction

  function automatic int exp_next(input int r, input int l, input int p);
    if (r != 0) return 0;
    case (m_phase)
      0: return (l != 0) ? 1 : 0;
      1: return (m_op == 6) ? 2 : 3;
      2: return (m_left == 1) ? 3 : 2;
      default: return (p == 0) ? 0 : ((l != 0) ? 1 : 3);
    endcase
  endfunction

  task automatic finish_alu();
    int mask, s;
    mask = (1 << W) - 1;
    m_c = 0; m_v = 0; m_hi = 0;
    case (m_op)
      0: begin
        s = m_a + m_b; m_c = (s > mask) ? 1 : 0;
        s = sgn(m_a) + sgn(m_b); m_v = (s > mask / 2 || s < -(mask / 2) - 1) ? 1 : 0;
        m_out = (m_a + m_b) & mask;
      end
      1: begin
        m_c = (m_a < m_b) ? 1 : 0;
        s = sgn(m_a) - sgn(m_b); m_v = (s > mask / 2 || s < -(mask / 2) - 1) ? 1 : 0;
        m_out = (m_a - m_b) & mask;
      end
      2: m_out = m_a & m_b;
      3: m_out = m_a | m_b;
      4: m_out = m_a ^ m_b;
      5: m_out = (~m_a) & mask;
      default: m_out = m_b;
    endcase
    m_z = (m_out == 0) ? 1 : 0;
  endtask

  task automatic model_edge(input int r, input int l, input int p, input int n1, input int n2, input int op);
    int prod;
    if (r != 0) begin
      m_phase = 0; m_a = 0; m_b = 0; m_op = 0; m_left = 0;
      m_out = 0; m_hi = 0; m_c = 0; m_v = 0; m_z = 0; m_done = 0;
      return;
    end
    m_done = 0;
    case (m_phase)
      0: if (l != 0) begin m_a = n1; m_b = n2; m_op = op; m_phase = 1; end
      1: begin
        if (m_op == 6) begin m_left = W; m_phase = 2; end
        else begin finish_alu(); m_phase = 3; m_done = 1; end
      end
      2: begin
        m_left--;
        if (m_left == 0) begin
          prod = m_a * m_b;
          m_out = prod % (1 << W); m_hi = prod / (1 << W);
          m_c = 0; m_v = 0; m_z = (prod == 0) ? 1 : 0;
          m_phase = 3; m_done = 1;
        end
      end
      default: begin
        if (p == 0) m_phase = 0;
        else if (l != 0) begin m_a = m_out; m_b = n2; m_op = op; m_phase = 1; end
      end
    endcase
  endtask

  task automatic cyc(input int r, input int l, input int p, input int n1, input int n2, input int op);
    reset = r[0]; load = l[0]; persist = p[0];
    num1 = n1[W-1:0]; num2 = n2[W-1:0]; op_sel = op[2:0];
    @(negedge clk);
    chk("nextState", {30'b0, nextState}, exp_next(r, l, p));
    @(posedge clk);
    model_edge(r, l, p, n1, n2, op);
    #1;
    chk("currState", {30'b0, currState}, m_phase);
    chk("out", {24'b0, out}, m_out);
    chk("out_hi", {24'b0, out_hi}, m_hi);
    chk("carry", {31'b0, carry}, m_c);
    chk("ovf", {31'b0, ovf}, m_v);
    chk("zero", {31'b0, zero}, m_z);
    chk("busy", {31'b0, busy}, (m_phase == 1 || m_phase == 2) ? 1 : 0);
    chk("done", {31'b0, done}, m_done);
  endtask

  initial begin
    int busy_cnt, done_cnt;
    m_phase = 0;
    reset = 1'b1; load = 1'b0; persist = 1'b0; num1 = '0; num2 = '0; op_sel = '0;

    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_out", {24'b0, out}, 0);
    chk("rst_state", {30'b0, currState}, 0);

    // ADD 0x57+0x1A, hold with persist
    cyc(0, 1, 0, 'h57, 'h1A, 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("plan_add", {24'b0, out}, 'h71);
    chk("plan_add_done", {31'b0, done}, 1);
    chk("plan_add_state", {30'b0, currState}, 3);
    cyc(0, 0, 1, 0, 0, 0);
    chk("plan_done_once", {31'b0, done}, 0);

    // chained accumulate; num1 must be ignored
    cyc(0, 1, 1, 'hFF, 'h01, 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("plan_chain", {24'b0, out}, 'h72);
    cyc(0, 1, 0, 0, 0, 0);
    chk("plan_chain_idle", {24'b0, out}, 'h72);
    chk("plan_chain_state", {30'b0, currState}, 0);

    // SUB with borrow, then signed overflow ADD
    cyc(0, 1, 0, 'h1A, 'h57, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("plan_sub", {24'b0, out}, 'hC3);
    chk("plan_sub_c", {31'b0, carry}, 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 'h7F, 'h01, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("plan_ovf", {31'b0, ovf}, 1);
    chk("plan_ovf_out", {24'b0, out}, 'h80);
    cyc(0, 0, 0, 0, 0, 0);

    // MUL with load pulses during BUSY
    busy_cnt = 0; done_cnt = 0;
    cyc(0, 1, 0, 'h57, 'h1A, 6);
    if (busy) busy_cnt++;
    for (int i = 0; i < W + 1; i++) begin
      cyc(0, i % 2, 0, 'hFF, 'hFF, 0);
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
    chk("plan_mul_lo", {24'b0, out}, 'hD6);
    chk("plan_mul_hi", {24'b0, out_hi}, 'h08);
    chk("plan_mul_busy", busy_cnt, W + 1);
    chk("plan_mul_done", done_cnt, 1);
    cyc(0, 0, 0, 0, 0, 0);

    // reset 4 cycles into a multiply
    cyc(0, 1, 0, 'h33, 'h44, 6);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("plan_abort_out", {24'b0, out}, 0);
    chk("plan_abort_state", {30'b0, currState}, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("plan_zero_add", {31'b0, zero}, 1);
    cyc(0, 0, 0, 0, 0, 0);

    // XOR to zero, NOT
    cyc(0, 1, 0, 'hAA, 'hAA, 4);
    cyc(0, 0, 0, 0, 0, 0);
    chk("plan_xor_zero", {31'b0, zero}, 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 'h0F, 'h00, 5);
    cyc(0, 0, 0, 0, 0, 0);
    chk("plan_not", {24'b0, out}, 'hF0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 59) == 0) ? 1 : 0,
          ($urandom_range(0, 2) != 0) ? 1 : 0,
          ($urandom_range(0, 3) != 0) ? 1 : 0,
          int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
          int'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
